// File: rtl/cnn16_mem_ctrl.sv
// cnn16_mem_ctrl: 4096 x 16 word memory controller with single-beat writes and
// burst reads (1..16 beats, READ_LAT cycles per beat, address wraps at 0xFFF).
// Optional per-word even parity is enabled with macro CNN16_MEM_PARITY_EN; with
// it undefined, storage is 16 bits, par_inj is ignored and par_err stays low.
// All outputs are registered; rst is synchronous and active low, and it never
// touches the memory array.
module cnn16_mem_ctrl #(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  input  logic [3:0]  burst_len,
  input  logic        par_inj,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        last,
  output logic        busy,
  output logic        par_err
);

`ifdef CNN16_MEM_PARITY_EN
  localparam int MEM_W = 17;
`else
  localparam int MEM_W = 16;
`endif

  // Cycles spent in RD_WAIT before each beat, minus one (unused when READ_LAT=1).
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  // Even parity bit over a data word.
  function automatic logic even_par(input logic [15:0] d);
    return ^d;
  endfunction

  state_t            state_q, state_d;
  logic [11:0]       addr_q, addr_d;
  logic [3:0]        rem_q, rem_d;
  logic [1:0]        wait_q, wait_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              par_err_q, par_err_d;

  logic [MEM_W-1:0]  mem_q [4096];
  logic              mem_we_s;
  logic [MEM_W-1:0]  mem_wdata_s;
  logic [MEM_W-1:0]  mem_rd_s;

`ifdef CNN16_MEM_PARITY_EN
  assign mem_wdata_s = {even_par(wdata) ^ par_inj, wdata};
`else
  logic unused_par_inj_s;
  assign unused_par_inj_s = par_inj;
  assign mem_wdata_s      = wdata;
`endif

  // The word for the beat about to be presented is the one at the next address.
  assign mem_rd_s = mem_q[addr_d];

  // Next-state logic and the next values of all registered outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    last_d    = 1'b0;
    par_err_d = 1'b0;
    mem_we_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = addr;
          if (we) begin
            mem_we_s = 1'b1;
            state_d  = WR_ACK;
          end else begin
            rem_d = burst_len;
            if (READ_LAT == 1) begin
              state_d = RD_DATA;
            end else begin
              state_d = RD_WAIT;
              wait_d  = WAIT_INIT;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ACK: begin
        state_d = IDLE;
      end
      RD_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = RD_DATA;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      RD_DATA: begin
        if (rem_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          rem_d  = rem_q - 4'd1;
          addr_d = addr_q + 12'd1;
          if (READ_LAT == 1) begin
            state_d = RD_DATA;
          end else begin
            state_d = RD_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    if (state_d == WR_ACK) begin
      ack_d  = 1'b1;
      last_d = 1'b1;
    end else if (state_d == RD_DATA) begin
      ack_d   = 1'b1;
      last_d  = (rem_d == 4'd0);
      rdata_d = mem_rd_s[15:0];
`ifdef CNN16_MEM_PARITY_EN
      par_err_d = ^mem_rd_s;
`else
      par_err_d = 1'b0;
`endif
    end else begin
      ack_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= 12'd0;
      rem_q     <= 4'd0;
      wait_q    <= 2'd0;
      rdata_q   <= 16'h0000;
      ack_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      par_err_q <= par_err_d;
    end
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      mem_q[addr] <= mem_wdata_s;
    end
  end

  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign last    = last_q;
  assign busy    = busy_q;
  assign par_err = par_err_q;

endmodule

// File: tb/tb_cnn16_mem_ctrl.sv
// Directed bench for cnn16_mem_ctrl: three instances with READ_LAT = 1, 2, 4
// share the same stimulus; each is checked cycle by cycle against a small
// word-array model of the memory.
module tb_cnn16_mem_ctrl;

`ifdef CNN16_MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [3:0]  burst_len;
  logic        par_inj;

  logic [15:0] rdata_o   [3];
  logic        ack_o     [3];
  logic        last_o    [3];
  logic        busy_o    [3];
  logic        par_err_o [3];

  logic [15:0] model_mem [4096];
  bit          model_inj [4096];
  logic [15:0] last_rd   [3];

  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cnn16_mem_ctrl #(.READ_LAT(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .burst_len (burst_len),
      .par_inj   (par_inj),
      .rdata     (rdata_o[g]),
      .ack       (ack_o[g]),
      .last      (last_o[g]),
      .busy      (busy_o[g]),
      .par_err   (par_err_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All outputs of every instance must show the reset/idle values.
  task automatic check_idle_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("%s ack L%0d", tag, 1 << g), ack_o[g], 1'b0);
      check_eq($sformatf("%s last L%0d", tag, 1 << g), last_o[g], 1'b0);
      check_eq($sformatf("%s busy L%0d", tag, 1 << g), busy_o[g], 1'b0);
      check_eq($sformatf("%s perr L%0d", tag, 1 << g), par_err_o[g], 1'b0);
      check_eq($sformatf("%s rdata L%0d", tag, 1 << g), rdata_o[g], 16'h0000);
    end
  endtask

  // Expected outputs in cycle c (c = 1 is the cycle after the request edge) of a read.
  task automatic check_cycle(input int c, input logic [11:0] a, input logic [3:0] bl);
    for (int g = 0; g < 3; g++) begin
      int          lat;
      int          span;
      int          k;
      logic [11:0] ba;
      logic        e_ack;
      logic        e_last;
      logic        e_busy;
      logic        e_pe;
      lat    = 1 << g;
      span   = (int'(bl) + 1) * lat;
      e_ack  = 1'b0;
      e_last = 1'b0;
      e_pe   = 1'b0;
      e_busy = (c <= span);
      if (c <= span && (c % lat) == 0) begin
        k          = c / lat - 1;
        ba         = a + 12'(k);
        e_ack      = 1'b1;
        e_last     = (k == int'(bl));
        e_pe       = PAR_ON && model_inj[ba];
        last_rd[g] = model_mem[ba];
      end
      check_eq($sformatf("rd ack L%0d c%0d", lat, c), ack_o[g], e_ack);
      check_eq($sformatf("rd last L%0d c%0d", lat, c), last_o[g], e_last);
      check_eq($sformatf("rd busy L%0d c%0d", lat, c), busy_o[g], e_busy);
      check_eq($sformatf("rd perr L%0d c%0d", lat, c), par_err_o[g], e_pe);
      check_eq($sformatf("rd data L%0d c%0d", lat, c), rdata_o[g], last_rd[g]);
    end
  endtask

  // Single write from idle; ack/last in the next cycle, idle the cycle after.
  task automatic run_write(input logic [11:0] a, input logic [15:0] d, input logic inj);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; par_inj = inj; burst_len = 4'd0;
    @(negedge clk);
    req = 1'b0; we = 1'b0; par_inj = 1'b0;
    model_mem[a] = d;
    model_inj[a] = inj;
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("wr ack L%0d a%h", 1 << g, a), ack_o[g], 1'b1);
      check_eq($sformatf("wr last L%0d a%h", 1 << g, a), last_o[g], 1'b1);
      check_eq($sformatf("wr busy L%0d a%h", 1 << g, a), busy_o[g], 1'b1);
      check_eq($sformatf("wr rdata hold L%0d", 1 << g), rdata_o[g], last_rd[g]);
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("wr end ack L%0d", 1 << g), ack_o[g], 1'b0);
      check_eq($sformatf("wr end busy L%0d", 1 << g), busy_o[g], 1'b0);
    end
  endtask

  // Burst read; optionally pulse a write request at cycle inj_c or reset at rst_c.
  task automatic run_read(input logic [11:0] a, input logic [3:0] bl,
                          input int inj_c, input int rst_c);
    int maxc;
    maxc = (int'(bl) + 1) * 4 + 1;
    req = 1'b1; we = 1'b0; addr = a; burst_len = bl; par_inj = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      req = 1'b0;
      check_cycle(c, a, bl);
      if (c == inj_c) begin
        req = 1'b1; we = 1'b1; addr = 12'h010; wdata = 16'hDEAD; par_inj = 1'b1;
      end else begin
        we = 1'b0; par_inj = 1'b0; addr = a;
      end
      if (c == rst_c) begin
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("midburst rst");
        rst = 1'b1;
        for (int g = 0; g < 3; g++) last_rd[g] = 16'h0000;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 12'h000;
    wdata = 16'h0000; burst_len = 4'd0; par_inj = 1'b0;
    for (int g = 0; g < 3; g++) last_rd[g] = 16'h0000;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Basic write then single-beat read.
    run_write(12'h005, 16'h3C00, 1'b0);
    run_read(12'h005, 4'd0, 0, 0);

    // Burst across the top of the address space.
    run_write(12'hFFE, 16'hA1A1, 1'b0);
    run_write(12'hFFF, 16'hA2A2, 1'b0);
    run_write(12'h000, 16'hA3A3, 1'b0);
    run_write(12'h001, 16'hA4A4, 1'b0);
    run_read(12'hFFE, 4'd3, 0, 0);

    // Request while busy must be dropped.
    run_write(12'h010, 16'h5A5A, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_write(12'h200 + 12'(i), 16'h7000 + 16'(i * 37), 1'b0);
    end
    run_read(12'h200, 4'd15, 5, 0);
    run_read(12'h010, 4'd0, 0, 0);

    // Reset in the middle of a 16-beat read; memory keeps its contents.
    run_read(12'h200, 4'd15, 0, 6);
    run_read(12'h005, 4'd0, 0, 0);
    run_read(12'h203, 4'd1, 0, 0);

    // Parity injection.
    run_write(12'h100, 16'h1234, 1'b1);
    run_read(12'h100, 4'd0, 0, 0);
    run_write(12'h101, 16'h1234, 1'b0);
    run_read(12'h101, 4'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn16_mem_ctrl.md
CNN16_MEM_CTRL -- requirements
Module: cnn16_mem_ctrl

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 2, giving read latency per beat in clock cycles; legal range 1..4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset (rst=0 sampled at a clk edge resets).
REQ-004 The block SHALL have port req, input, 1 bit: access request, sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read, captured with req.
REQ-006 The block SHALL have port addr, input, 12 bits: word address, captured with req.
REQ-007 The block SHALL have port wdata, input, 16 bits: write data, captured with req.
REQ-008 The block SHALL have port burst_len, input, 4 bits: read beats minus one, captured with req; ignored for writes.
REQ-009 The block SHALL have port par_inj, input, 1 bit: when 1 at write capture, stores inverted parity.
REQ-010 The block SHALL have port rdata, output, 16 bits: read data, updated only on read beats, held otherwise.
REQ-011 The block SHALL have port ack, output, 1 bit: one-cycle pulse per completed write or read beat.
REQ-012 The block SHALL have port last, output, 1 bit: high with the ack of the final beat of a transfer.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have port par_err, output, 1 bit: high with a read ack whose stored parity mismatches.

Function
REQ-015 Storage SHALL be 4096 words x 16 bits (17 bits with parity), indexed by the captured address.
REQ-016 The FSM SHALL have states IDLE, WR_ACK, RD_WAIT, RD_DATA.
REQ-017 In IDLE, req=1 at edge T0 SHALL capture we/addr/wdata/burst_len and leave IDLE.
REQ-018 A write SHALL update mem[addr] at T0, go to WR_ACK, drive ack=1 and last=1 during cycle T0+1, then return to IDLE.
REQ-019 A read SHALL deliver beat k (k=0..burst_len) with ack=1 in cycle T0+(k+1)*READ_LAT, using RD_WAIT for the READ_LAT-1 preceding cycles and RD_DATA for the ack cycle.
REQ-020 With READ_LAT=1, RD_WAIT SHALL be skipped, giving back-to-back acks.
REQ-021 Beat address SHALL increment by one per beat modulo 4096 (0xFFF wraps to 0x000).
REQ-022 A read SHALL end after burst_len+1 beats, with last=1 on the final ack, and return to IDLE on the next edge.
REQ-023 req asserted while busy=1 SHALL be ignored without queuing; the initiator re-requests after busy falls.
REQ-024 A new request SHALL be accepted no earlier than the first cycle after the final ack (IDLE with busy=0).
REQ-025 Outside ack cycles, ack, last and par_err SHALL be 0.

Reset
REQ-026 rst=0 at any edge, including mid-burst, SHALL force state IDLE and set ack=0, last=0, busy=0, par_err=0 and rdata=0x0000.
REQ-027 Reset SHALL NOT clear memory contents.

Configuration
REQ-028 With macro CNN16_MEM_PARITY_EN defined, each word SHALL store an even-parity bit (inverted when par_inj=1), check it on every read beat, and drive par_err with the ack.
REQ-029 Without CNN16_MEM_PARITY_EN, storage SHALL be 16 bits, par_inj SHALL be ignored and par_err SHALL be tied to 0; the port list SHALL be unchanged.

Verification
REQ-030 With READ_LAT=2, after reset write 0x3C00 to 0x005 -> ack=last=1 at T0+1; then read 0x005 -> ack=1 at T0+2 with rdata=0x3C00 and busy=0 in the next cycle.
REQ-031 Preload 0xFFE/0xFFF/0x000/0x001 = A1/A2/A3/A4, then read with burst_len=3 from 0xFFE -> 4 acks at T0+2/4/6/8 with rdata A1..A4, and last only on the 4th.
REQ-032 During a READ_LAT=4 read, pulse req with we=1 to 0x010 -> request ignored and mem[0x010] unchanged.
REQ-033 Drive rst=0 during beat 2 of a 16-beat read -> next cycle ack=busy=0 and rdata=0; a later read of a pre-written word returns its prior value.
REQ-034 With CNN16_MEM_PARITY_EN, write 0x1234 with par_inj=1, then read -> par_err=1 with ack; with par_inj=0 -> par_err=0; without the macro -> par_err=0 always.
